shift_unit_arbiter: RTL

- Shares one 16-bit logical-right barrel shifter (barrel_shifter_16bit, ctrl = shift amount) between two requesters, A and B.
- Arbitration is round-robin. Each side uses a valid/ready handshake.
- Result goes into a single registered output stage with backpressure, tagged with the requester ID.
- Sits between the execution-lane issue logic and the writeback mux.

---
 rtl/shift_unit_arbiter_if.sv | 49 ++++
 rtl/shift_unit_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/shift_unit_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | Module      : shift_unit_arbiter_if                                        |
// | Description : Requester A/B and result handshake bundle for the shared     |
// |               shift unit.                                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface shift_unit_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int AMT_W  = 4
);
  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic [AMT_W-1:0]  a_amt;
  logic              a_ready;

  logic              b_valid;
  logic [DATA_W-1:0] b_data;
  logic [AMT_W-1:0]  b_amt;
  logic              b_ready;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_id;
  logic              out_ready;

  // Requesters and the downstream consumer
  modport master (
    output a_valid, a_data, a_amt,
    input  a_ready,
    output b_valid, b_data, b_amt,
    input  b_ready,
    input  out_valid, out_data, out_id,
    output out_ready
  );

  // The arbiter itself
  modport slave (
    input  a_valid, a_data, a_amt,
    output a_ready,
    input  b_valid, b_data, b_amt,
    output b_ready,
    output out_valid, out_data, out_id,
    input  out_ready
  );
endinterface

`default_nettype wire

// File: rtl/shift_unit_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : shift_unit_arbiter                                           |
// | Description : Round-robin sharing of one 16-bit logical right shifter      |
// |               between two requesters, registered tagged output stage.      |
// |               Optional grant counters: define SHIFT_ARB_STATS_EN.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module barrel_shifter_16bit (
  input  logic [15:0] data_in,
  input  logic [3:0]  ctrl,
  output logic [15:0] data_out
);
  logic [15:0] w_stage [0:4];

  assign w_stage[0] = data_in;

  // Stage s shifts by 2**s when ctrl[s] is set, zero filling from the top
  for (genvar s = 0; s < 4; s++) begin : g_stage
    assign w_stage[s+1] = ctrl[s] ? (w_stage[s] >> (1 << s)) : w_stage[s];
  end

  assign data_out = w_stage[4];
endmodule

module shift_unit_arbiter #(
  parameter int DATA_W = 16,
  parameter int AMT_W  = 4
`ifdef SHIFT_ARB_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  logic                clk,
  input  logic                rst,
  shift_unit_arbiter_if.slave bus
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]   a_grant_cnt,
  output logic [STAT_W-1:0]   b_grant_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_id;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_id;

  logic              w_can_accept;
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_acc_a;
  logic              w_acc_b;
  logic              w_accept;
  logic [DATA_W-1:0] w_sh_in;
  logic [AMT_W-1:0]  w_sh_amt;
  logic [DATA_W-1:0] w_sh_out;

  // Grant ignores out_ready so a stalled winner keeps its grant until accepted
  always_comb begin
    w_state_nxt  = r_state;
    w_can_accept = (r_state == ST_EMPTY) || bus.out_ready;
    w_grant_a    = bus.a_valid && (!bus.b_valid || r_last_id);
    w_grant_b    = bus.b_valid && (!bus.a_valid || !r_last_id);
    w_acc_a      = w_grant_a && w_can_accept && !rst;
    w_acc_b      = w_grant_b && w_can_accept && !rst;
    w_accept     = w_acc_a || w_acc_b;

    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_accept) begin
          w_state_nxt = ST_FULL;
        end else if (bus.out_ready) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_sh_in  = w_grant_b ? bus.b_data : bus.a_data;
  assign w_sh_amt = w_grant_b ? bus.b_amt  : bus.a_amt;

  barrel_shifter_16bit u_shifter (
    .data_in  (w_sh_in),
    .ctrl     (w_sh_amt),
    .data_out (w_sh_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= '0;
      r_out_id   <= 1'b0;
      r_last_id  <= 1'b1;
    end else if (w_accept) begin
      r_out_data <= w_sh_out;
      r_out_id   <= w_acc_b;
      r_last_id  <= w_acc_b;
    end
  end

  assign bus.a_ready   = w_acc_a;
  assign bus.b_ready   = w_acc_b;
  assign bus.out_valid = (r_state == ST_FULL);
  assign bus.out_data  = r_out_data;
  assign bus.out_id    = r_out_id;

`ifdef SHIFT_ARB_STATS_EN
  logic [STAT_W-1:0] r_a_cnt;
  logic [STAT_W-1:0] r_b_cnt;

  // Counters stick at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_cnt <= '0;
      r_b_cnt <= '0;
    end else begin
      if (w_acc_a && (r_a_cnt != {STAT_W{1'b1}})) begin
        r_a_cnt <= r_a_cnt + {{(STAT_W-1){1'b0}}, 1'b1};
      end
      if (w_acc_b && (r_b_cnt != {STAT_W{1'b1}})) begin
        r_b_cnt <= r_b_cnt + {{(STAT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign a_grant_cnt = r_a_cnt;
  assign b_grant_cnt = r_b_cnt;
`else
  // Grant statistics not built in this configuration
`endif

endmodule

`default_nettype wire
